// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
// Optional parity cycle is enabled with the PARITY_EN macro.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10
    } piso_state_e;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

    localparam logic RST_X_OUT      = 1'b0;
    localparam logic RST_X_VALID    = 1'b0;
    localparam logic RST_DONE       = 1'b0;
    localparam logic RST_LOAD_READY = 1'b1;

    // Counter width for an arbitrary word width.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one frame; flags the last data bit at WIDTH-1.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en)    cnt <= cnt + CW'(1);
    end

    assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Valid/ready word in, one bit per clk out, done flag on the final frame cycle.
// Define PARITY_EN to append an even-parity bit after each word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             done
);

    localparam int CW = cnt_w(WIDTH);

    piso_state_e      state, nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

    assign accept = load_valid && load_ready;

    // Counter runs only inside SHIFT; any other situation parks it at zero.
    piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (accept || (state != SHIFT) || last),
        .en    (state == SHIFT),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (accept) nxt = SHIFT;
            SHIFT: if (last) begin
`ifdef PARITY_EN
                nxt = PAR;
`else
                nxt = accept ? SHIFT : IDLE;
`endif
            end
`ifdef PARITY_EN
            PAR:   nxt = accept ? SHIFT : IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                shreg <= '0;
        else if (accept)          shreg <= load_data;
        else if (state == SHIFT)  shreg <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                                            : {1'b0, shreg[WIDTH-1:1]};
    end

`ifdef PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       par_q <= 1'b0;
        else if (accept) par_q <= ^load_data;
    end
`endif

    always_comb begin
        x_out      = RST_X_OUT;
        x_valid    = RST_X_VALID;
        done       = RST_DONE;
        load_ready = RST_LOAD_READY;
        case (state)
            SHIFT: begin
                x_out   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
                x_valid = 1'b1;
`ifdef PARITY_EN
                load_ready = 1'b0;
`else
                done       = last;
                load_ready = last;
`endif
            end
`ifdef PARITY_EN
            PAR: begin
                x_out   = par_q;
                x_valid = 1'b1;
                done    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers driven in lockstep.
module tb_piso_serializer;

    localparam int W = 4;

    typedef struct packed { logic x; logic d; } bit_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         rdy_m, x_m, v_m, done_m;
    logic         rdy_l, x_l, v_l, done_l;

    bit_t q_m[$];
    bit_t q_l[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   rdy_exp;

    always #20 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_m), .x_out(x_m), .x_valid(v_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_l), .x_out(x_l), .x_valid(v_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
`ifdef PARITY_EN
            q_m.push_back('{x: w[W-1-i], d: 1'b0});
            q_l.push_back('{x: w[i],     d: 1'b0});
`else
            q_m.push_back('{x: w[W-1-i], d: (i == W-1)});
            q_l.push_back('{x: w[i],     d: (i == W-1)});
`endif
        end
`ifdef PARITY_EN
        q_m.push_back('{x: ^w, d: 1'b1});
        q_l.push_back('{x: ^w, d: 1'b1});
`endif
    endtask

    // Ready is expected in idle and on the final cycle of a frame.
    task automatic mon_one(input string tag, inout bit_t q[$],
                           input logic rdy, input logic x, input logic v, input logic dn);
        bit_t e;
        chk({tag, ".ready"}, rdy, q.size() <= 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ".valid"}, v, 1'b1);
            chk({tag, ".x"},     x, e.x);
            chk({tag, ".done"},  dn, e.d);
        end else begin
            chk({tag, ".valid"}, v, 1'b0);
            chk({tag, ".x"},     x, 1'b0);
            chk({tag, ".done"},  dn, 1'b0);
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, output bit acc);
        @(negedge clk);
        rdy_exp = (q_m.size() <= 1);
        mon_one("msb", q_m, rdy_m, x_m, v_m, done_m);
        mon_one("lsb", q_l, rdy_l, x_l, v_l, done_l);
        load_valid = v;
        load_data  = d;
        acc = v && rdy_exp;
        if (acc) push_frame(d);
    endtask

    task automatic send(input logic [W-1:0] w);
        bit acc = 0;
        for (int i = 0; i < 20 && !acc; i++) cyc(1'b1, w, acc);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), acc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".x_m"}, x_m, 0);  chk({tag, ".v_m"}, v_m, 0);
        chk({tag, ".d_m"}, done_m, 0); chk({tag, ".r_m"}, rdy_m, 1);
        chk({tag, ".x_l"}, x_l, 0);  chk({tag, ".v_l"}, v_l, 0);
        chk({tag, ".d_l"}, done_l, 0); chk({tag, ".r_l"}, rdy_l, 1);
    endtask

    initial begin
        bit acc;
        reset = 1'b1; load_valid = 1'b0; load_data = 4'b1010;
        // Load pulse across a rising edge while reset is held must be ignored.
        #10 load_valid = 1'b1;
        #20 load_valid = 1'b0;
        #15 chk_reset_vals("in_reset");
        #5  reset = 1'b0;
        idle(3);

        send(4'b1011);                      // single word
        idle(6);

        send(4'b1011); send(4'b0110);       // back-to-back
        idle(10);

        send(4'b1011); send(4'b1111);       // held off while busy
        idle(10);

        send(4'b1001);                      // reset mid-frame
        cyc(1'b0, 4'b0000, acc);
        cyc(1'b0, 4'b0000, acc);
        @(posedge clk);
        #5 reset = 1'b1;
        #1 chk_reset_vals("mid_reset");
        q_m.delete(); q_l.delete();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        send(4'b0011);
        idle(7);

        for (int k = 0; k < 12; k++) begin
            send(W'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(12);
        chk("drain_m", q_m.size(), 0);
        chk("drain_l", q_l.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
